// File: rtl/layer_out_serializer.sv
// -----------------------------------------------------------------------------
// layer_out_serializer
//
// Reads a neuron layer's parallel result vector in a single valid/ready
// handshake, then streams the elements out one per beat on a valid/ready
// interface. While streaming it tracks a running signed argmax. When the last
// beat has been accepted it reports the final argmax for one cycle.
//
// Ports
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   cap_valid     in   data_in holds a valid vector
//   cap_ready     out  block is idle and will accept a vector
//   data_in       in   LAYER_NUM signed elements, element i at
//                      bits [i*OUT_W +: OUT_W]
//   out_valid     out  out_data/out_index/out_last are valid
//   out_ready     in   downstream accepts the current beat
//   out_data      out  signed element
//   out_index     out  element index 0..LAYER_NUM-1
//   out_last      out  high on the beat with index LAYER_NUM-1
//   argmax_valid  out  one-cycle pulse, argmax result updated
//   argmax_idx    out  index of the largest element (lowest index on tie)
//   argmax_val    out  value of the largest element
//
// FSM states
//   state  | meaning
//   S_IDLE | waiting for a vector, cap_ready=1
//   S_SEND | streaming buffered elements, one per accepted beat
//   S_DONE | one cycle, argmax_valid=1, then back to S_IDLE
// -----------------------------------------------------------------------------
module layer_out_serializer #(
    parameter  int LAYER_DATA_WIDTH = 16,
    parameter  int LAYER_NUM        = 10,
    localparam int OUT_W            = LAYER_DATA_WIDTH + 8,
    localparam int IDX_W            = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cap_valid,
    output logic                       cap_ready,
    input  logic [LAYER_NUM*OUT_W-1:0] data_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_W-1:0]           out_data,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_last,
    output logic                       argmax_valid,
    output logic [IDX_W-1:0]           argmax_idx,
    output logic [OUT_W-1:0]           argmax_val
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [OUT_W-1:0]        elem_buf [LAYER_NUM];
    logic [IDX_W-1:0]        idx;
    logic signed [OUT_W-1:0] run_val;
    logic [IDX_W-1:0]        run_idx;

    logic                    cap_fire;
    logic                    out_fire;
    logic                    is_last;
    logic signed [OUT_W-1:0] cur_elem;
    logic                    run_upd;

    // ------------------------------------------------------------------
    // Handshake qualifiers and current element
    // ------------------------------------------------------------------
    assign cap_fire = cap_valid && (state == S_IDLE);
    assign out_fire = out_ready && (state == S_SEND);
    assign is_last  = (idx == LAST_IDX);
    assign cur_elem = elem_buf[idx];

    // Element 0 always seeds the running maximum; afterwards only a strictly
    // larger value replaces it, which keeps the lowest index on ties.
    assign run_upd  = (idx == '0) || (cur_elem > run_val);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cap_fire) begin
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (out_fire && is_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cap_ready    = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_index    = '0;
        out_last     = 1'b0;
        argmax_valid = 1'b0;
        case (state)
            S_IDLE: begin
                cap_ready = 1'b1;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = cur_elem;
                out_index = idx;
                out_last  = is_last;
            end
            S_DONE: begin
                argmax_valid = 1'b1;
            end
            default: begin
                cap_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Vector buffer. Contents are don't-care until the first capture, so it
    // carries no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (cap_fire) begin
            for (int i = 0; i < LAYER_NUM; i++) begin
                elem_buf[i] <= data_in[i*OUT_W +: OUT_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (cap_fire) begin
            idx <= '0;
        end else if (out_fire && !is_last) begin
            idx <= idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Running argmax
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_val <= '0;
            run_idx <= '0;
        end else if (out_fire && run_upd) begin
            run_val <= cur_elem;
            run_idx <= idx;
        end
    end

    // The published result folds in the last element on the final transfer,
    // so it is already settled while S_DONE raises argmax_valid. It then holds
    // until the next vector completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            argmax_val <= '0;
            argmax_idx <= '0;
        end else if (out_fire && is_last) begin
            argmax_val <= run_upd ? cur_elem : run_val;
            argmax_idx <= run_upd ? idx      : run_idx;
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
module tb_layer_out_serializer;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int OW = DW + 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cap_valid = 1'b0;
    logic            cap_ready;
    logic [N*OW-1:0] data_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [OW-1:0]   out_data;
    logic [IW-1:0]   out_index;
    logic            out_last;
    logic            argmax_valid;
    logic [IW-1:0]   argmax_idx;
    logic [OW-1:0]   argmax_val;

    layer_out_serializer #(
        .LAYER_DATA_WIDTH(DW),
        .LAYER_NUM       (N)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_valid   (cap_valid),
        .cap_ready   (cap_ready),
        .data_in     (data_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last),
        .argmax_valid(argmax_valid),
        .argmax_idx  (argmax_idx),
        .argmax_val  (argmax_val)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [IW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [OW-1:0] val;
    } am_t;

    beat_t beat_q[$];
    am_t   am_q[$];

    logic signed [OW-1:0] vec [N];

    int errors = 0;
    int checks = 0;
    int xfers  = 0;

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic [IW-1:0] prev_idx;
    logic          prev_last;
    logic          accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, req);
        end
    endtask

    task automatic set_vec(input int a, input int b, input int c, input int d);
        vec[0] = OW'(a);
        vec[1] = OW'(b);
        vec[2] = OW'(c);
        vec[3] = OW'(d);
        for (int i = 0; i < N; i++) data_in[i*OW +: OW] = vec[i];
    endtask

    // Scoreboard push at capture: the beats in order plus the reference argmax.
    task automatic push_vec();
        logic signed [OW-1:0] best;
        logic [IW-1:0]        best_i;
        beat_t                b;
        am_t                  m;
        best   = vec[0];
        best_i = '0;
        for (int i = 0; i < N; i++) begin
            b.data = vec[i];
            b.idx  = IW'(i);
            b.last = (i == N - 1);
            beat_q.push_back(b);
            if (vec[i] > best) begin
                best   = vec[i];
                best_i = IW'(i);
            end
        end
        m.idx = best_i;
        m.val = best;
        am_q.push_back(m);
    endtask

    // Called at a falling edge: drives out_ready for the coming rising edge,
    // checks what the DUT presents now, then advances one clock.
    task automatic cycle(input logic rdy);
        beat_t b;
        am_t   m;
        out_ready = rdy;
        accepted  = 1'b0;
        if (prev_stall) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_data", 32'(out_data), 32'(prev_data));
            chk("stall_index", 32'(out_index), 32'(prev_idx));
            chk("stall_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && rdy) begin
            xfers++;
            chk("beat_expected", 32'(beat_q.size() > 0), 1);
            if (beat_q.size() > 0) begin
                b = beat_q.pop_front();
                chk("beat_data", 32'(out_data), 32'(b.data));
                chk("beat_index", 32'(out_index), 32'(b.idx));
                chk("beat_last", 32'(out_last), 32'(b.last));
            end
        end
        if (argmax_valid) begin
            chk("argmax_expected", 32'(am_q.size() > 0), 1);
            chk("done_cap_ready", 32'(cap_ready), 0);
            if (am_q.size() > 0) begin
                m = am_q.pop_front();
                chk("argmax_idx", 32'(argmax_idx), 32'(m.idx));
                chk("argmax_val", 32'(argmax_val), 32'(m.val));
            end
        end
        if (cap_valid && cap_ready) begin
            push_vec();
            accepted = 1'b1;
        end
        prev_stall = out_valid && !rdy;
        prev_data  = out_data;
        prev_idx   = out_index;
        prev_last  = out_last;
        @(negedge clk);
    endtask

    task automatic capture();
        cap_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1);
            if (accepted) break;
        end
        chk("capture_accepted", 32'(accepted), 1);
        cap_valid = 1'b0;
    endtask

    task automatic drain(input bit alt);
        for (int i = 0; i < 100; i++) begin
            if (beat_q.size() == 0 && am_q.size() == 0 && !out_valid && !argmax_valid) break;
            cycle(alt ? logic'(i % 2 == 0) : 1'b1);
        end
        chk("drain_beats_left", 32'(beat_q.size()), 0);
        chk("drain_argmax_left", 32'(am_q.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;

        // 1. reset
        @(negedge clk);
        chk("rst_cap_ready", 32'(cap_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_index", 32'(out_index), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_argmax_valid", 32'(argmax_valid), 0);
        chk("rst_argmax_idx", 32'(argmax_idx), 0);
        chk("rst_argmax_val", 32'(argmax_val), 0);
        rst_n = 1'b1;
        cycle(1'b0);
        cycle(1'b1);
        chk("idle_cap_ready", 32'(cap_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);

        // 2. full-rate stream with exact timing
        set_vec(5, -3, 12, 7);
        capture();
        for (int k = 0; k < N; k++) begin
            chk("t2_beat_valid", 32'(out_valid), 1);
            chk("t2_beat_index", 32'(out_index), 32'(k));
            chk("t2_cap_ready_send", 32'(cap_ready), 0);
            cycle(1'b1);
        end
        chk("t2_done_pulse", 32'(argmax_valid), 1);
        chk("t2_done_out_valid", 32'(out_valid), 0);
        chk("t2_argmax_idx", 32'(argmax_idx), 2);
        chk("t2_argmax_val", 32'(argmax_val), 12);
        cycle(1'b1);
        chk("t2_idle_cap_ready", 32'(cap_ready), 1);
        chk("t2_idle_pulse_gone", 32'(argmax_valid), 0);
        chk("t2_argmax_hold_idx", 32'(argmax_idx), 2);
        chk("t2_argmax_hold_val", 32'(argmax_val), 12);

        // 3. same vector, alternating out_ready
        capture();
        drain(1'b1);
        chk("t3_argmax_idx", 32'(argmax_idx), 2);
        chk("t3_argmax_val", 32'(argmax_val), 12);

        // 4. negatives with a tie
        set_vec(-8, -2, -2, -9);
        capture();
        drain(1'b0);
        chk("t4_argmax_idx", 32'(argmax_idx), 1);
        chk("t4_argmax_val", 32'(argmax_val), 32'h0000_FFFE);

        // 5. reset in the middle of a stream
        set_vec(1, 2, 3, 4);
        capture();
        cycle(1'b1);
        cycle(1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_abort_out_valid", 32'(out_valid), 0);
        chk("t5_abort_pulse", 32'(argmax_valid), 0);
        chk("t5_abort_cap_ready", 32'(cap_ready), 1);
        beat_q.delete();
        am_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_no_out_valid", 32'(out_valid), 0);
            chk("t5_no_pulse", 32'(argmax_valid), 0);
            cycle(1'b1);
        end
        set_vec(4, 3, 2, 1);
        capture();
        chk("t5_restart_index", 32'(out_index), 0);
        drain(1'b0);
        chk("t5_argmax_idx", 32'(argmax_idx), 0);
        chk("t5_argmax_val", 32'(argmax_val), 4);

        // 6. cap_valid held high across two vectors
        set_vec(10, 20, 30, -40);
        cap_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1);
            if (accepted) break;
        end
        chk("t6_first_accept", 32'(accepted), 1);
        set_vec(-1, -5, 7, 7);
        gap = 0;
        accepted = 1'b0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1);
            gap++;
            if (accepted) break;
        end
        cap_valid = 1'b0;
        chk("t6_second_accept", 32'(accepted), 1);
        chk("t6_accept_gap", 32'(gap), N + 2);
        drain(1'b0);
        chk("t6_argmax_idx", 32'(argmax_idx), 2);
        chk("t6_argmax_val", 32'(argmax_val), 7);

        chk("total_transfers", 32'(xfers), 26);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
